// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, block type, FSM state type and key-schedule helpers
package aes_pkg;
    localparam logic [3:0] AES_NR    = 4'd10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;
    typedef logic [127:0] block_t;
    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} aes_state_e;
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
    endfunction
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box (GF(2^8) inverse followed by the affine transform)
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] b;
        p = 8'h00;
        b = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) p = p ^ b;
            b = xtime(b);
        end
        return p;
    endfunction
    // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int k = 0; k < 7; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction
    logic [7:0] inv;
    always_comb begin
        inv      = gf_inv(in_byte);
        out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                   {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: AES-128 on-the-fly round-key generator; define AES_KEYEXP_STORE_EN to add an 11-entry key table with rd_idx/rd_key readout
module aes_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
`ifdef AES_KEYEXP_STORE_EN
    ,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
`endif
);
    aes_state_e state_q, state_d;
    block_t     rk_data_q, rk_data_d, next_key;
    logic [3:0] rk_idx_q, rk_idx_d;
    logic [7:0] rcon_q, rcon_d;
    logic       rk_valid_q, rk_valid_d;
    logic       accept;
    logic [31:0] rot_w, sub_w, t;
    assign rot_w  = rot_word(rk_data_q[31:0]);
    assign accept = rk_valid_q & rk_ready;
    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (.in_byte(rot_w[8*i +: 8]), .out_byte(sub_w[8*i +: 8]));
    end
    always_comb begin
        t                = sub_w ^ {rcon_q, 24'h0};
        next_key[127:96] = rk_data_q[127:96] ^ t;
        next_key[95:64]  = rk_data_q[95:64] ^ next_key[127:96];
        next_key[63:32]  = rk_data_q[63:32] ^ next_key[95:64];
        next_key[31:0]   = rk_data_q[31:0] ^ next_key[63:32];
    end
    always_comb begin
        state_d    = state_q;
        rk_data_d  = rk_data_q;
        rk_idx_d   = rk_idx_q;
        rcon_d     = rcon_q;
        rk_valid_d = rk_valid_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d    = ST_EXPAND;
                rk_data_d  = key_in;
                rk_idx_d   = 4'd0;
                rcon_d     = RCON_INIT;
                rk_valid_d = 1'b1;
            end
            ST_EXPAND: if (accept) begin
                if (rk_idx_q == AES_NR) begin
                    rk_valid_d = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    rk_data_d = next_key;
                    rk_idx_d  = rk_idx_q + 4'd1;
                    rcon_d    = xtime(rcon_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rk_data_q  <= '0;
            rk_idx_q   <= 4'd0;
            rcon_q     <= RCON_INIT;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            rcon_q     <= rcon_d;
            rk_valid_q <= rk_valid_d;
        end
    end
    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_data_q;
    assign rk_idx   = rk_idx_q;
    assign busy     = state_q == ST_EXPAND;
    assign done     = state_q == ST_DONE;
`ifdef AES_KEYEXP_STORE_EN
    // table is deliberately not reset so keys survive for reverse-order readout
    block_t tbl_q [0:10];
    block_t rd_key_q, rd_key_d;
    always_comb rd_key_d = (rd_idx <= AES_NR) ? tbl_q[rd_idx] : '0;
    always_ff @(posedge clk) begin
        if (accept && !reset) tbl_q[rk_idx_q] <= rk_data_q;
        rd_key_q <= reset ? '0 : rd_key_d;
    end
    assign rd_key = rd_key_q;
`endif
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed self-checking bench for aes_key_expand against FIPS-197 key schedules
module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         rk_ready = 1'b1;
    logic         rk_valid, busy, done;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    int n_vec = 0;
    int n_err = 0;
    logic [127:0] k1 [11];
    logic [127:0] k2 [11];
`ifdef AES_KEYEXP_STORE_EN
    logic [3:0]   rd_idx = 4'd0;
    logic [127:0] rd_key;
`endif
    always #5 clk = ~clk;
    aes_key_expand dut (
        .clk(clk), .reset(reset), .start(start), .key_in(key_in), .rk_ready(rk_ready),
        .rk_valid(rk_valid), .rk_data(rk_data), .rk_idx(rk_idx), .busy(busy), .done(done)
`ifdef AES_KEYEXP_STORE_EN
        , .rd_idx(rd_idx), .rd_key(rd_key)
`endif
    );
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [127:0] exp_key(input int which, input int n);
        if (n < 0 || n > 10) return '0;
        return which == 1 ? k1[n] : k2[n];
    endfunction
    // mode 0: ready held high; 1: random ready with a 3-cycle stall at idx5; 2: stray start at idx4
    task automatic run(input int which, input int mode);
        int  n, cyc, stall;
        bit  inj;
        n = 0; cyc = 0; stall = 0; inj = 0;
        @(negedge clk);
        start = 1'b1; key_in = exp_key(which, 0); rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; key_in = ~key_in; cyc = 1;
        chk("first_valid", 128'(rk_valid), 128'(1));
        while (!done && cyc < 200) begin
            if (rk_valid) begin
                chk("rk_idx", 128'(rk_idx), 128'(n));
                chk("rk_data", rk_data, exp_key(which, n));
                chk("busy", 128'(busy), 128'(1));
            end
            if (mode == 1) begin
                if (n == 5 && stall < 3) begin
                    rk_ready = 1'b0;
                    stall++;
                end else rk_ready = (n == 5) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            start = (mode == 2 && n == 4 && !inj);
            if (start) begin
                inj = 1;
                key_in = k1[10] ^ k2[3];
            end
            if (rk_valid && rk_ready) n++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        rk_ready = 1'b1;
        chk("done", 128'(done), 128'(1));
        chk("key_count", 128'(n), 128'(11));
        if (mode != 1) chk("latency", 128'(cyc), 128'(12));
        chk("done_busy", 128'(busy), 128'(0));
        @(negedge clk);
        chk("done_pulse", 128'(done), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_valid", 128'(rk_valid), 128'(0));
    endtask
    initial begin
        int cyc;
        k1[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        k1[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        k1[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        k1[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        k1[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        k1[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        k1[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        k1[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        k1[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        k1[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        k1[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        k2[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        k2[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        k2[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        k2[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        k2[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        k2[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        k2[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        k2[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        k2[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        k2[9]  = 128'hac7766f319fadc2128d12941575c006e;
        k2[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_valid", 128'(rk_valid), 128'(0));
        chk("rst_data", rk_data, '0);
        chk("rst_idx", 128'(rk_idx), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        run(1, 0);
`ifdef AES_KEYEXP_STORE_EN
        for (int i = 10; i >= 0; i--) begin
            rd_idx = 4'(i);
            @(negedge clk);
            chk("rd_key", rd_key, k1[i]);
        end
        rd_idx = 4'd15;
        @(negedge clk);
        chk("rd_oob", rd_key, '0);
`endif
        run(2, 0);
        run(2, 1);
        run(1, 2);
        @(negedge clk);
        start = 1'b1; key_in = k2[0];
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(rk_valid && rk_idx == 4'd6) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_idx6", 128'(rk_idx), 128'(6));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_valid", 128'(rk_valid), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_idx", 128'(rk_idx), 128'(0));
        chk("mid_rst_data", rk_data, '0);
        chk("mid_rst_done", 128'(done), 128'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done", 128'(done), 128'(0));
        end
        run(2, 0);
        reset = 1'b1; start = 1'b1; key_in = k1[0];
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("rst_start_valid", 128'(rk_valid), 128'(0));
        chk("rst_start_busy", 128'(busy), 128'(0));
        @(negedge clk);
        chk("rst_start_idle", 128'(rk_valid), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
